// File: rtl/toggle_reg_exerciser.sv
// ---------------------------------------------------------------------------
// toggle_reg_exerciser
//   Self-test companion for the load/toggle register design. A run drives
//   NUM_VECTORS (sel, data) vectors from a Galois LFSR into the register
//   under test. It tracks the expected register contents in a local model
//   and compares each readback, which returns RETURN_DELAY stages late. It
//   reports done/pass, a saturating mismatch count and the index of the
//   first failing vector.
//
// Ports
//   i_Clock       rising-edge clock
//   i_Reset_n     asynchronous active-low reset
//   i_Start       start request, honoured only when idle or done
//   o_Sel/o_Data  vector to the register under test (1 = load, 0 = toggle)
//   i_Data        register readback, RETURN_DELAY stages after its output
//   o_Busy        run in progress (vectors or draining)
//   o_Done        run finished, results valid until the next start
//   o_Pass        o_Done with no mismatches
//   o_ErrorCount  mismatches this run, saturating at all-ones
//   o_FirstErr    vector index of the first mismatch
// ---------------------------------------------------------------------------
module toggle_reg_exerciser #(
  parameter int unsigned NUM_VECTORS  = 256,
  parameter logic [15:0] LFSR_TAPS    = 16'hB400,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned RETURN_DELAY = 0,
  parameter int unsigned ERR_W        = 16,
  localparam int unsigned IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Start,
  output logic             o_Sel,
  output logic             o_Data,
  input  logic             i_Data,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Pass,
  output logic [ERR_W-1:0] o_ErrorCount,
  output logic [IDX_W-1:0] o_FirstErr
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Right-shifting Galois LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] i_Value);
    return {1'b0, i_Value[15:1]} ^ (i_Value[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  state_t           r_State;
  state_t           w_StateNext;
  logic [15:0]      r_Lfsr;
  logic [15:0]      w_LfsrNext;
  logic [15:0]      w_LfsrStep;
  logic [IDX_W-1:0] r_VecIdx;
  logic [IDX_W-1:0] w_VecIdxNext;
  logic             r_Sel;
  logic             r_Data;
  logic             w_SelNext;
  logic             w_DataNext;
  logic             r_VecValid;
  logic             w_VecValidNext;
  logic             w_Launch;
  logic             r_Model;
  logic             r_ModelValid;
  logic             w_ExpBit;
  logic             w_CmpValid;
  logic             w_Mismatch;
  logic [IDX_W-1:0] r_CmpIdx;
  logic [IDX_W-1:0] w_CmpIdxNext;
  logic [ERR_W-1:0] r_ErrCount;
  logic [ERR_W-1:0] w_ErrNext;
  logic [IDX_W-1:0] r_FirstErr;
  logic [IDX_W-1:0] w_FirstNext;
  logic             r_Busy;
  logic             r_Done;
  logic             r_Pass;

  assign w_LfsrStep = lfsr_step(r_Lfsr);

  // Next state, vector generation and start acceptance.
  always_comb begin
    w_StateNext    = r_State;
    w_Launch       = 1'b0;
    w_SelNext      = 1'b0;
    w_DataNext     = 1'b0;
    w_VecValidNext = 1'b0;
    w_LfsrNext     = r_Lfsr;
    w_VecIdxNext   = r_VecIdx;
    case (r_State)
      ST_IDLE, ST_DONE: begin
        if (i_Start) begin
          // Vector 0 is a forced load: the register under test has no reset.
          w_StateNext    = ST_RUN;
          w_Launch       = 1'b1;
          w_SelNext      = 1'b1;
          w_DataNext     = SEED_EFF[1];
          w_VecValidNext = 1'b1;
          w_LfsrNext     = SEED_EFF;
          w_VecIdxNext   = {IDX_W{1'b0}};
        end else begin
          w_StateNext = r_State;
        end
      end
      ST_RUN: begin
        if (r_VecIdx == LAST_IDX) begin
          w_StateNext = ST_DRAIN;
        end else begin
          w_LfsrNext     = w_LfsrStep;
          w_SelNext      = w_LfsrStep[0];
          w_DataNext     = w_LfsrStep[1];
          w_VecValidNext = 1'b1;
          w_VecIdxNext   = r_VecIdx + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (w_CmpValid && (r_CmpIdx == LAST_IDX)) begin
          w_StateNext = ST_DONE;
        end else begin
          w_StateNext = ST_DRAIN;
        end
      end
      default: begin
        w_StateNext = ST_IDLE;
      end
    endcase
  end

  // State, vector outputs and LFSR registers.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State    <= ST_IDLE;
      r_Lfsr     <= SEED_EFF;
      r_VecIdx   <= {IDX_W{1'b0}};
      r_Sel      <= 1'b0;
      r_Data     <= 1'b0;
      r_VecValid <= 1'b0;
    end else begin
      r_State    <= w_StateNext;
      r_Lfsr     <= w_LfsrNext;
      r_VecIdx   <= w_VecIdxNext;
      r_Sel      <= w_SelNext;
      r_Data     <= w_DataNext;
      r_VecValid <= w_VecValidNext;
    end
  end

  // Reference register: captures the driven vector on the same edge as the
  // register under test. The tag marks the captures that belong to a run.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Model      <= 1'b0;
      r_ModelValid <= 1'b0;
    end else begin
      r_Model      <= r_Sel ? r_Data : ~r_Model;
      r_ModelValid <= r_VecValid;
    end
  end

  // Delay the model value and its tag to line up with the returning readback.
  if (RETURN_DELAY > 0) begin : g_align
    logic [RETURN_DELAY-1:0] r_MPipe;
    logic [RETURN_DELAY-1:0] r_VPipe;

    // Alignment shift registers for the expected bit and its valid tag.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
        r_MPipe <= {RETURN_DELAY{1'b0}};
        r_VPipe <= {RETURN_DELAY{1'b0}};
      end else begin
        r_MPipe[0] <= r_Model;
        r_VPipe[0] <= r_ModelValid;
        for (int i = 1; i < RETURN_DELAY; i++) begin
          r_MPipe[i] <= r_MPipe[i-1];
          r_VPipe[i] <= r_VPipe[i-1];
        end
      end
    end

    assign w_ExpBit   = r_MPipe[RETURN_DELAY-1];
    assign w_CmpValid = r_VPipe[RETURN_DELAY-1];
  end else begin : g_noalign
    assign w_ExpBit   = r_Model;
    assign w_CmpValid = r_ModelValid;
  end

  assign w_Mismatch = w_CmpValid && (i_Data != w_ExpBit);

  // Compare bookkeeping: compare index, saturating count, first failure.
  always_comb begin
    w_CmpIdxNext = r_CmpIdx;
    w_ErrNext    = r_ErrCount;
    w_FirstNext  = r_FirstErr;
    if (w_Launch) begin
      w_CmpIdxNext = {IDX_W{1'b0}};
      w_ErrNext    = {ERR_W{1'b0}};
      w_FirstNext  = {IDX_W{1'b0}};
    end else if (w_CmpValid) begin
      w_CmpIdxNext = r_CmpIdx + IDX_W'(1);
      if (w_Mismatch) begin
        // The count never returns to zero within a run, so zero means this is
        // the first mismatch.
        if (r_ErrCount == {ERR_W{1'b0}}) begin
          w_FirstNext = r_CmpIdx;
        end else begin
          w_FirstNext = r_FirstErr;
        end
        if (r_ErrCount != ERR_MAX) begin
          w_ErrNext = r_ErrCount + ERR_W'(1);
        end else begin
          w_ErrNext = r_ErrCount;
        end
      end else begin
        w_ErrNext = r_ErrCount;
      end
    end else begin
      w_CmpIdxNext = r_CmpIdx;
    end
  end

  // Result and status registers, aligned with the state they describe.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_CmpIdx   <= {IDX_W{1'b0}};
      r_ErrCount <= {ERR_W{1'b0}};
      r_FirstErr <= {IDX_W{1'b0}};
      r_Busy     <= 1'b0;
      r_Done     <= 1'b0;
      r_Pass     <= 1'b0;
    end else begin
      r_CmpIdx   <= w_CmpIdxNext;
      r_ErrCount <= w_ErrNext;
      r_FirstErr <= w_FirstNext;
      r_Busy     <= (w_StateNext == ST_RUN) || (w_StateNext == ST_DRAIN);
      r_Done     <= (w_StateNext == ST_DONE);
      r_Pass     <= (w_StateNext == ST_DONE) && (w_ErrNext == {ERR_W{1'b0}});
    end
  end

  assign o_Sel        = r_Sel;
  assign o_Data       = r_Data;
  assign o_Busy       = r_Busy;
  assign o_Done       = r_Done;
  assign o_Pass       = r_Pass;
  assign o_ErrorCount = r_ErrCount;
  assign o_FirstErr   = r_FirstErr;

endmodule
